seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, cycles all anodes are off at the start of each digit slot; legal range 1 to REFRESH_DIV-1.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port value, input, 16: four hex nibbles; value[3:0] is digit 0 (rightmost).
REQ-006 SHALL have port load, input, 1: one-cycle strobe that captures value.
REQ-007 SHALL have port en, input, 1: display enable.
REQ-008 SHALL have port sel, output, 2: current digit index, feeding the downstream digit-select mux.
REQ-009 SHALL have port an, output, 4: anodes, active-low; an[i] drives digit i.
REQ-010 SHALL have port seg, output, 7: cathodes {g,f,e,d,c,b,a}, active-low.

Function
REQ-011 Prescaler: SHALL count 0..REFRESH_DIV-1 and wrap; tick SHALL be the cycle where it equals REFRESH_DIV-1 and en=1.
REQ-012 On tick, sel SHALL increment modulo 4 (3 wraps to 0); sel SHALL change only on tick.
REQ-013 FSM states are BLANK and SHOW; tick SHALL force BLANK with blank counter cleared, in either state.
REQ-014 BLANK SHALL last exactly BLANK_CYCLES cycles, then move to SHOW; SHOW SHALL hold until the next tick.
REQ-015 In BLANK, an SHALL be 4'b1111; in SHOW, an SHALL be all ones except an[sel]=0.
REQ-016 seg SHALL be the registered decode of nibble disp[4*sel+3 -: 4]: standard hex glyphs 0-F; 0=1000000, 8=0000000, F=0001110; update latency 1 cycle after sel changes, which falls inside BLANK.
REQ-017 load=1 SHALL write value into shadow and set pending; a later load before the frame boundary SHALL overwrite shadow (last write wins).
REQ-018 Frame boundary = tick with sel going 3 to 0; if pending, disp SHALL take shadow and pending SHALL clear.
REQ-019 If load coincides with a frame boundary, disp SHALL take the old shadow; shadow SHALL take the new value; pending SHALL stay 1, so the new value shows one frame later.
REQ-020 en=0 SHALL force an=4'b1111 the same cycle (combinational gate) and freeze prescaler, blank counter, sel and FSM; load capture SHALL still work.
REQ-021 Re-enable SHALL resume from the frozen state with no restart of the current slot.

Reset
REQ-022 rst_n=0 SHALL asynchronously set: prescaler=0, sel=0, FSM=BLANK, blank counter=0, disp=0, shadow=0, pending=0, an=4'b1111, seg=7'b1000000.
REQ-023 After rst_n release, an SHALL stay 4'b1111 for BLANK_CYCLES cycles (with en=1), then show digit 0.
REQ-024 Reset mid-slot or mid-load SHALL discard pending data; no partial update of disp.

Configuration
REQ-025 Macro SEG_SCAN_LZ_BLANK_EN defined: in SHOW, digit i (i = 3..1) SHALL keep an[i]=1 when disp nibbles i..3 are all zero; digit 0 SHALL always be shown.
REQ-026 Macro undefined: all four digits SHALL be shown, including leading zeros; no leading-zero logic is synthesized.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1, en=1 unless stated)
REQ-027 Reset release -> an=1111 for 1 cycle, then 1110 with seg=1000000; sel steps 0,1,2,3,0 every 4 cycles.
REQ-028 load value=16'h8F30 mid-frame -> disp unchanged until sel 3 to 0; next frame digits show 0,3,F,8 (seg 1000000, 0110000, 0001110, 0000000).
REQ-029 load 16'h1111 on the exact 3-to-0 tick after a pending 16'h2222 -> frame shows 2222, following frame shows 1111.
REQ-030 en=0 for 10 cycles during SHOW of digit 2 -> an=1111 immediately, sel stays 2; en=1 -> an=1011 resumes, slot completes the remaining cycles.
REQ-031 With SEG_SCAN_LZ_BLANK_EN, disp=16'h0005 -> only an[0] ever goes low; disp=16'h0000 -> digit 0 shows 0; without the macro, all four anodes pulse.
REQ-032 rst_n pulsed low mid-SHOW with a pending load -> an=1111 asynchronously; after release disp=0, pending load lost.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Purpose: four-digit multiplexed 7-segment scan controller with double-buffered display data.
// Latency: load shows at the next frame boundary; seg is registered (1 cycle after sel changes).
// Backpressure: none; load is always accepted, en=0 freezes the scan and blanks anodes at once.
//
// Ports: clk, rst_n (async, active-low); value[15:0] + load strobe into the shadow buffer;
//        en display enable; sel[1:0] current digit; an[3:0] anodes (active-low);
//        seg[6:0] cathodes {g,f,e,d,c,b,a} (active-low).
// Option: define SEG_SCAN_LZ_BLANK_EN to suppress leading-zero digits (digit 0 always shown).
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        en,
  output logic [1:0]  sel,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q;
  logic [BW-1:0]   blank_q, blank_d;
  logic [15:0]     disp_q, shadow_q;
  logic            pending_q;
  logic            tick;
  logic            frame_end;
  logic            lz_hide;
  logic [3:0]      cur_nib;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // The prescaler is frozen while disabled, so tick can only fire with en=1.
  assign tick      = en && (pre_q == PRE_LAST);
  assign frame_end = tick && (sel == 2'd3);
  assign cur_nib   = disp_q[{sel, 2'b00} +: 4];

`ifdef SEG_SCAN_LZ_BLANK_EN
  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    lz_hide = 1'b0;
    case (sel)
      2'd1:    lz_hide = (disp_q[15:4]  == 12'h000);
      2'd2:    lz_hide = (disp_q[15:8]  == 8'h00);
      2'd3:    lz_hide = (disp_q[15:12] == 4'h0);
      default: lz_hide = 1'b0;
    endcase
  end
`else
  assign lz_hide = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (en) begin
      pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= 2'd0;
    end else if (tick) begin
      sel <= sel + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
    end
  end

  // Next state and anode drive. A tick restarts the blanking window from either state.
  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    an      = 4'b1111;
    if (tick) begin
      state_d = ST_BLANK;
      blank_d = '0;
    end else if (en && (state_q == ST_BLANK)) begin
      if (blank_q == BLANK_LAST) begin
        state_d = ST_SHOW;
        blank_d = '0;
      end else begin
        blank_d = blank_q + 1'b1;
      end
    end
    if (en && (state_q == ST_SHOW) && !lz_hide) begin
      an[sel] = 1'b0;
    end
  end

  // Double buffer: disp only changes at a frame boundary, taking the shadow value
  // as it stood before this cycle; a coincident load stays pending for next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
      disp_q    <= 16'h0000;
    end else begin
      if (frame_end && pending_q) begin
        disp_q <= shadow_q;
      end
      if (load) begin
        shadow_q  <= value;
        pending_q <= 1'b1;
      end else if (frame_end) begin
        pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'b1000000;
    end else begin
      seg <= hex_glyph(cur_nib);
    end
  end

endmodule
